alu_step_sequencer: RTL

Operand-entry and execution controller for the switch-driven 8-bit ALU datapath. It debounces one step button, walks the user through loading operand A, then operand B with its opcode, and holds both stable for the ALU. It then waits a settle window, captures the ALU result and flags it valid for the LEDs and seven-segment path. It sits between the board I/O (switches, button, clock divider tick) and the ALU core, replacing direct button-to-register loading.

---
 rtl/alu_seq_pkg.sv | 14 +
 rtl/btn_debounce.sv | 54 +++++
 rtl/alu_step_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// State encodings shared by the step sequencer,
// the display mux and the LED logic.
package alu_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Step button conditioner: 2-flop sync, tick-sampled
// stability counter and a one-clk rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn,
    output logic step
);

    localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       step_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Saturating increment so a stuck mismatch never wraps to zero.
    assign cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            step_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            step_q  <= 1'b0;
            if (tick) begin
                if (sync2_q != level_q) begin
                    if (cnt_d == TICKS) begin
                        level_q <= sync2_q;
                        cnt_q   <= 4'd0;
                        step_q  <= sync2_q;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end else begin
                    cnt_q <= 4'd0;
                end
            end
        end
    end

    assign step = step_q;

endmodule

// File: rtl/alu_step_sequencer.sv
// Operand-entry FSM: loads A, then B/opcode, holds them
// for a settle window and captures the ALU result.
module alu_step_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned SETTLE_CYCLES  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               btn_step,
    input  logic               btn_clear,
    input  logic [3:0]         sw_op_sel,
    input  logic [7:0]         sw_input_bits,
    input  logic [7:0]         alu_y,
    output logic [7:0]         a_reg,
    output logic [7:0]         b_reg,
    output logic [3:0]         op_reg,
    output logic [7:0]         result,
    output logic               result_valid,
    output logic [STATE_W-1:0] state
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic       step;
    logic       clr_s1_q;
    logic       clr_s2_q;
    seq_state_e state_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [3:0] op_q;
    logic [7:0] res_q;
    logic       valid_q;
    logic [3:0] cnt_q;

    btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_step_db (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .btn    (btn_step),
        .step   (step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            state_q  <= GET_A;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            op_q     <= 4'd0;
            res_q    <= 8'd0;
            valid_q  <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            clr_s1_q <= btn_clear;
            clr_s2_q <= clr_s1_q;
            // Abort wins over a coincident step; operands are kept.
            if (clr_s2_q) begin
                state_q <= GET_A;
                valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    GET_A: begin
                        if (step) begin
                            a_q     <= sw_input_bits;
                            state_q <= GET_B;
                        end
                    end
                    GET_B: begin
                        if (step) begin
                            b_q     <= sw_input_bits;
                            op_q    <= sw_op_sel;
                            cnt_q   <= SETTLE_LAST;
                            state_q <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (cnt_q == 4'd0) begin
                            res_q   <= alu_y;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    DONE: begin
                        if (step) begin
                            valid_q <= 1'b0;
                            a_q     <= sw_input_bits;
                            state_q <= GET_B;
                        end
                    end
                endcase
            end
        end
    end

    assign a_reg        = a_q;
    assign b_reg        = b_q;
    assign op_reg       = op_q;
    assign result       = res_q;
    assign result_valid = valid_q;
    assign state        = state_q;

endmodule
